// File: rtl/msrv32_prefetch_unit.sv
// ---------------------------------------------------------------------------
// msrv32_prefetch_unit
//
// Instruction prefetcher for the msrv32 core. It issues pipelined AHB-style
// fetches (the address phase of one access overlaps the data phase of the
// previous one) and queues the returned words with their PCs in a small FIFO
// that the decode stage drains through a valid/ready handshake. A redirect
// (flush) empties the queue, restarts fetching at the new target and throws
// away any response still owed by memory.
//
// Parameters
//   BOOT_ADDRESS : first fetch address after reset
//   DEPTH        : instruction buffer entries (2, 4, 8 or 16)
//
// Ports
//   clk_in               : clock, all state changes on the rising edge
//   rst_in               : synchronous active-high reset
//   imaddr_out           : instruction memory address (address phase)
//   instr_req_out        : address phase valid
//   instr_in             : instruction memory read data (data phase)
//   instr_hready_in      : memory ready; low stretches the current phases
//   flush_in             : redirect request
//   flush_pc_in          : redirect target
//   instr_out            : head-of-buffer instruction
//   instr_pc_out         : PC of instr_out
//   instr_valid_out      : instr_out / instr_pc_out valid
//   instr_ready_in       : consumer accepts the head entry
//   misaligned_instr_out : last redirect target was not word aligned
//   count_out            : buffer occupancy
//
// Optional feature
//   MSRV32_PREFETCH_BYPASS_EN : when defined, a word returning into an empty
//   buffer is forwarded straight to instr_out in the same cycle, saving one
//   cycle of fetch latency.
// ---------------------------------------------------------------------------
module msrv32_prefetch_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
  parameter int          DEPTH        = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  output logic [31:0]              imaddr_out,
  output logic                     instr_req_out,
  input  logic [31:0]              instr_in,
  input  logic                     instr_hready_in,
  input  logic                     flush_in,
  input  logic [31:0]              flush_pc_in,
  output logic [31:0]              instr_out,
  output logic [31:0]              instr_pc_out,
  output logic                     instr_valid_out,
  input  logic                     instr_ready_in,
  output logic                     misaligned_instr_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  typedef enum logic [1:0] {FETCH, STALL, DRAIN, MISALIGN} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic            req_q;
  logic            dphase_valid;
  logic            dphase_discard;
  logic [31:0]     dphase_pc;
  logic            misaligned;
  logic [31:0]     buf_instr [DEPTH];
  logic [31:0]     buf_pc    [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            addr_accept;
  logic            data_done;
  logic            buf_push;
  logic            buf_pop;
  logic [CW-1:0]   count_next;
  logic            room;
`ifdef MSRV32_PREFETCH_BYPASS_EN
  logic            bypass_hit;
`endif

  // fetch_pc doubles as the live address-phase register: it only moves when
  // the current address phase is accepted or a redirect arrives.
  assign imaddr_out           = fetch_pc;
  assign instr_req_out        = req_q;
  assign misaligned_instr_out = misaligned;
  assign count_out            = count;

  // Issue decision looks at the occupancy after this edge plus the access
  // that becomes a data phase at this edge, so every issued request already
  // owns a free buffer slot and a push can never overflow.
  always_comb begin
    addr_accept = req_q && instr_hready_in;
    data_done   = dphase_valid && instr_hready_in && !dphase_discard && !flush_in;
    buf_pop     = (count != '0) && instr_ready_in && !flush_in;
`ifdef MSRV32_PREFETCH_BYPASS_EN
    bypass_hit  = data_done && (count == '0);
    buf_push    = data_done && !(bypass_hit && instr_ready_in);
`else
    buf_push    = data_done;
`endif
    count_next  = count + CW'(buf_push) - CW'(buf_pop);
    room        = ({1'b0, count_next} + {{CW{1'b0}}, req_q}) < DEPTH_W;
  end

  always_comb begin
    instr_out       = buf_instr[rd_ptr];
    instr_pc_out    = buf_pc[rd_ptr];
    instr_valid_out = (count != '0);
`ifdef MSRV32_PREFETCH_BYPASS_EN
    if (bypass_hit) begin
      instr_out       = instr_in;
      instr_pc_out    = dphase_pc;
      instr_valid_out = 1'b1;
    end
`endif
  end

  // Storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge clk_in) begin
    if (buf_push) begin
      buf_instr[wr_ptr] <= instr_in;
      buf_pc[wr_ptr]    <= dphase_pc;
    end
  end

  // A flush withdraws any pending address phase and marks whatever data
  // phase is still owed as stale; DRAIN waits for that stale response so it
  // cannot be mistaken for the first word at the new target.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= FETCH;
      fetch_pc       <= BOOT_ADDRESS;
      req_q          <= 1'b0;
      dphase_valid   <= 1'b0;
      dphase_discard <= 1'b0;
      dphase_pc      <= '0;
      misaligned     <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
    end else if (flush_in) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      fetch_pc       <= flush_pc_in;
      req_q          <= 1'b0;
      dphase_discard <= 1'b1;
      if (instr_hready_in) begin
        dphase_valid <= req_q;
        dphase_pc    <= fetch_pc;
      end
      if (flush_pc_in[1:0] != 2'b00) begin
        state      <= MISALIGN;
        misaligned <= 1'b1;
      end else begin
        misaligned <= 1'b0;
        state      <= (instr_hready_in ? req_q : dphase_valid) ? DRAIN : FETCH;
      end
    end else begin
      if (buf_push) wr_ptr <= wr_ptr + AW'(1);
      if (buf_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      if (instr_hready_in) begin
        dphase_valid   <= req_q;
        dphase_pc      <= fetch_pc;
        dphase_discard <= 1'b0;
        if (addr_accept) fetch_pc <= fetch_pc + 32'd4;
        case (state)
          FETCH, STALL: begin
            req_q <= room;
            state <= room ? FETCH : STALL;
          end
          DRAIN: begin
            req_q <= 1'b0;
            state <= FETCH;
          end
          default: req_q <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msrv32_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_msrv32_prefetch_unit
//
// Bench for msrv32_prefetch_unit (BOOT_ADDRESS=0x100, DEPTH=4, default
// build). The bench acts as the instruction memory, returning
// mem_word(addr) for every accepted address, and keeps a queue of the
// words the consumer must see. Every cycle the DUT is compared against that
// queue, the expected next fetch address and the misaligned flag; directed
// scenarios add hand-computed literal expectations on top.
// ---------------------------------------------------------------------------
module tb_msrv32_prefetch_unit;

  localparam logic [31:0] BOOT  = 32'h00000100;
  localparam int          DEPTH = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] imaddr_out;
  logic        instr_req_out;
  logic [31:0] instr_in;
  logic        instr_hready_in;
  logic        flush_in;
  logic [31:0] flush_pc_in;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic        misaligned_instr_out;
  logic [2:0]  count_out;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] m_pc;
  logic        m_misaligned;
  logic        pend_valid;
  logic        pend_stale;
  logic [31:0] pend_addr;
  logic        model_on;
  int          vectors;
  int          miscompares;
  int          accepts;

  always #5 clk_in = ~clk_in;

  msrv32_prefetch_unit #(
    .BOOT_ADDRESS(BOOT),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .imaddr_out          (imaddr_out),
    .instr_req_out       (instr_req_out),
    .instr_in            (instr_in),
    .instr_hready_in     (instr_hready_in),
    .flush_in            (flush_in),
    .flush_pc_in         (flush_pc_in),
    .instr_out           (instr_out),
    .instr_pc_out        (instr_pc_out),
    .instr_valid_out     (instr_valid_out),
    .instr_ready_in      (instr_ready_in),
    .misaligned_instr_out(misaligned_instr_out),
    .count_out           (count_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the queue model.
  task automatic modelCompare();
    int live;
    if (!model_on) return;
    live = (pend_valid && !pend_stale) ? 1 : 0;
    checkOutput("count", 32'(count_out), 32'(exp_q.size()));
    checkOutput("valid", 32'(instr_valid_out), (exp_q.size() != 0) ? 32'd1 : 32'd0);
    if (exp_q.size() != 0) begin
      checkOutput("instr", instr_out, exp_q[0].instr);
      checkOutput("pc", instr_pc_out, exp_q[0].pc);
    end
    checkOutput("misaligned", 32'(misaligned_instr_out), 32'(m_misaligned));
    if (m_misaligned) checkOutput("req_while_misaligned", 32'(instr_req_out), 32'd0);
    if (instr_req_out) begin
      checkOutput("imaddr", imaddr_out, m_pc);
      checkOutput("reservation", (exp_q.size() + live + 1 <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
    end
  endtask

  // Advance the model by what the coming rising edge must do.
  task automatic modelEdge();
    logic accept;
    if (rst_in) begin
      exp_q.delete();
      m_pc         = BOOT;
      m_misaligned = 1'b0;
      pend_valid   = 1'b0;
      pend_stale   = 1'b0;
      model_on     = 1'b1;
      return;
    end
    accept = instr_req_out && instr_hready_in;
    if (accept) accepts++;
    if (exp_q.size() != 0 && instr_ready_in && !flush_in) void'(exp_q.pop_front());
    if (pend_valid && instr_hready_in && !pend_stale && !flush_in)
      exp_q.push_back(entry_t'{instr: mem_word(pend_addr), pc: pend_addr});
    if (flush_in) begin
      exp_q.delete();
      m_pc         = flush_pc_in;
      m_misaligned = (flush_pc_in[1:0] != 2'b00);
    end else if (accept) begin
      m_pc = m_pc + 32'd4;
    end
    if (instr_hready_in) begin
      pend_valid = accept;
      pend_addr  = imaddr_out;
      pend_stale = flush_in;
    end else if (flush_in) begin
      pend_stale = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    modelCompare();
    modelEdge();
    @(posedge clk_in);
    #1;
    instr_in = pend_valid ? mem_word(pend_addr) : 32'hBAD0BAD0;
  endtask

  task automatic applyStimulus(input logic hr, input logic rd, input logic fl,
                               input logic [31:0] fpc, input int n);
    instr_hready_in = hr;
    instr_ready_in  = rd;
    flush_in        = fl;
    flush_pc_in     = fpc;
    repeat (n) step();
    flush_in = 1'b0;
  endtask

  task automatic waitValid(input string name, input int limit);
    logic found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (instr_valid_out) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  task automatic waitInFlight(input string name, input int limit);
    logic found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (instr_req_out && pend_valid) begin
        found = 1'b1;
        break;
      end
      step();
    end
    checkOutput(name, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    vectors         = 0;
    miscompares     = 0;
    accepts         = 0;
    model_on        = 1'b0;
    pend_valid      = 1'b0;
    pend_stale      = 1'b0;
    pend_addr       = '0;
    m_pc            = BOOT;
    m_misaligned    = 1'b0;
    rst_in          = 1'b1;
    instr_hready_in = 1'b1;
    instr_ready_in  = 1'b1;
    flush_in        = 1'b0;
    flush_pc_in     = '0;
    instr_in        = 32'hBAD0BAD0;

    // Reset state and first fetches from BOOT_ADDRESS.
    step();
    step();
    checkOutput("rst_req", 32'(instr_req_out), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid_out), 32'd0);
    checkOutput("rst_count", 32'(count_out), 32'd0);
    checkOutput("rst_misaligned", 32'(misaligned_instr_out), 32'd0);
    rst_in = 1'b0;
    step();
    checkOutput("first_req", 32'(instr_req_out), 32'd1);
    checkOutput("first_addr", imaddr_out, 32'h00000100);
    step();
    checkOutput("second_addr", imaddr_out, 32'h00000104);
    checkOutput("valid_too_early", 32'(instr_valid_out), 32'd0);
    step();
    checkOutput("third_addr", imaddr_out, 32'h00000108);
    checkOutput("first_valid", 32'(instr_valid_out), 32'd1);
    checkOutput("first_pc", instr_pc_out, 32'h00000100);
    checkOutput("first_instr", instr_out, 32'hC0DE0113);
    step();
    checkOutput("second_pc", instr_pc_out, 32'h00000104);

    // Full buffer with a stalled consumer, then a single pop.
    rst_in = 1'b1;
    step();
    rst_in  = 1'b0;
    accepts = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 12);
    checkOutput("fill_requests", 32'(accepts), 32'd4);
    checkOutput("fill_count", 32'(count_out), 32'd4);
    checkOutput("fill_req_low", 32'(instr_req_out), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("pop_count", 32'(count_out), 32'd3);
    checkOutput("pop_head", instr_pc_out, 32'h00000104);
    accepts = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 6);
    checkOutput("refill_requests", 32'(accepts), 32'd1);
    checkOutput("refill_count", 32'(count_out), 32'd4);

    // Wait states during the data phase of 0x08.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000000, 1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_req_out && imaddr_out == 32'h00000008) begin
        found = 1'b1;
        step();
        break;
      end
      step();
    end
    checkOutput("find_addr_08", 32'(found), 32'd1);
    checkOutput("pre_wait_count", 32'(count_out), 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1);
      checkOutput("wait_addr_held", imaddr_out, 32'h0000000C);
      checkOutput("wait_req_held", 32'(instr_req_out), 32'd1);
      checkOutput("wait_no_push", 32'(count_out), 32'd2);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
    checkOutput("post_wait_count", 32'(count_out), 32'd3);
    checkOutput("post_wait_head", instr_pc_out, 32'h00000000);
    step();
    checkOutput("post_wait_count2", 32'(count_out), 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 8);

    // Flush with a live data phase, memory ready.
    waitInFlight("inflight_a", 10);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h00000200, 1);
    checkOutput("flush_count", 32'(count_out), 32'd0);
    checkOutput("flush_valid", 32'(instr_valid_out), 32'd0);
    checkOutput("flush_req_drain", 32'(instr_req_out), 32'd0);
    waitValid("flush_refetch", 10);
    checkOutput("flush_pc", instr_pc_out, 32'h00000200);
    checkOutput("flush_instr", instr_out, 32'hC0DE0213);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 4);

    // Flush while the data phase is stretched by wait states.
    waitInFlight("inflight_b", 10);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h00000240, 1);
    checkOutput("flush_wait_count", 32'(count_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1);
    checkOutput("drain_req_low", 32'(instr_req_out), 32'd0);
    instr_hready_in = 1'b1;
    waitValid("drain_refetch", 10);
    checkOutput("drain_pc", instr_pc_out, 32'h00000240);

    // Misaligned redirect, then recovery with an aligned one.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000202, 1);
    checkOutput("mis_flag", 32'(misaligned_instr_out), 32'd1);
    checkOutput("mis_count", 32'(count_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
      checkOutput("mis_no_req", 32'(instr_req_out), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000300, 1);
    checkOutput("mis_clear", 32'(misaligned_instr_out), 32'd0);
    waitValid("mis_refetch", 10);
    checkOutput("mis_resume_pc", instr_pc_out, 32'h00000300);

    // Steady push+pop at occupancy 2, then random consumer readiness.
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (count_out == 3'd2) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1);
    end
    checkOutput("reach_count2", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1);
      checkOutput("steady_count2", 32'(count_out), 32'd2);
    end
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
